// File: rtl/w_cpu_io_nibble_bridge.sv
// w_cpu_io_nibble_bridge: CPU-side bridge serialising 32-bit words to fabric nibbles and assembling fabric byte beats into words.
module w_cpu_io_nibble_bridge #(
  parameter int TX_NIBBLES = 8,
  parameter int RX_BEATS   = 4
) (
  input  logic        UserCLK,
  input  logic        rst_n,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic [2:0]  rx_bytes,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        err_ovf,
  output logic        err_abort,
  input  logic        err_clr,
  output logic [3:0]  OPA_O,
  output logic [3:0]  OPB_O,
  input  logic [3:0]  RES0_I,
  input  logic [3:0]  RES1_I,
  input  logic [3:0]  RES2_I
);
  localparam int TW = 4 * TX_NIBBLES;
  localparam int RW = 8 * RX_BEATS;
  localparam logic [2:0] LAST_NIB = 3'(TX_NIBBLES - 1);
  localparam logic [1:0] LAST_BEAT = 2'(RX_BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state, w_state_nx;
  logic [TW-1:0]   r_word, w_word_nx;
  logic [2:0]      r_cnt, w_cnt_nx;
  logic [3:0]      w_opa_nx, w_opb_nx, w_nib;
  logic            w_abort, w_xfer;

  assign w_abort  = RES2_I[3];
  assign w_xfer   = OPB_O[0] & RES2_I[2];
  assign tx_ready = (r_state == IDLE);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_word_nx  = r_word;
    w_opa_nx   = OPA_O;
    w_opb_nx   = OPB_O;
    w_nib      = '0;
    if (w_abort) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
      w_opa_nx   = '0;
      w_opb_nx   = '0;
    end else if (r_state == IDLE) begin
      if (tx_valid) begin
        w_word_nx  = tx_data[TW-1:0];
        w_state_nx = SEND;
        w_cnt_nx   = '0;
        w_opa_nx   = tx_data[3:0];
        w_opb_nx   = {^tx_data[3:0], 1'b0, 1'b1, 1'b1};
      end
    end else if (w_xfer) begin
      if (r_cnt == LAST_NIB) begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
        w_opa_nx   = '0;
        w_opb_nx   = '0;
      end else begin
        w_cnt_nx = r_cnt + 3'd1;
        w_nib    = r_word[4*w_cnt_nx +: 4];
        w_opa_nx = w_nib;
        w_opb_nx = {^w_nib, w_cnt_nx == LAST_NIB, 1'b0, 1'b1};
      end
    end
  end

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      OPA_O   <= '0;
      OPB_O   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_word  <= w_word_nx;
      OPA_O   <= w_opa_nx;
      OPB_O   <= w_opb_nx;
    end
  end

  logic [1:0]    r_bcnt;
  logic [RW-1:0] r_part, w_asm;
  logic [7:0]    w_byte;
  logic          w_beat, w_done, w_ovf_set;

  assign w_byte    = {RES1_I, RES0_I};
  assign w_beat    = RES2_I[0] & ~w_abort;
  assign w_done    = w_beat & (RES2_I[1] | (r_bcnt == LAST_BEAT));
  // Partial register is cleared after every word, so bytes above the last beat read as zero
  assign w_asm     = r_part | (RW'(w_byte) << (8 * r_bcnt));
  assign w_ovf_set = w_done & rx_valid & ~rx_ready;

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt    <= '0;
      r_part    <= '0;
      rx_data   <= '0;
      rx_bytes  <= '0;
      rx_valid  <= 1'b0;
      err_ovf   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      if (w_abort || w_done) begin
        r_bcnt <= '0;
        r_part <= '0;
      end else if (w_beat) begin
        r_bcnt <= r_bcnt + 2'd1;
        r_part <= w_asm;
      end
      if (w_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= 32'(w_asm);
          rx_bytes <= 3'(r_bcnt) + 3'd1;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      err_ovf   <= w_ovf_set | (err_ovf & ~err_clr);
      err_abort <= w_abort | (err_abort & ~err_clr);
    end
  end
endmodule

// File: tb/tb_w_cpu_io_nibble_bridge.sv
// tb_w_cpu_io_nibble_bridge: directed vector bench for the CPU/fabric nibble bridge.
module tb_w_cpu_io_nibble_bridge;
  logic        UserCLK = 1'b0;
  logic        rst_n;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic [2:0]  rx_bytes;
  logic        rx_valid;
  logic        rx_ready;
  logic        err_ovf;
  logic        err_abort;
  logic        err_clr;
  logic [3:0]  OPA_O;
  logic [3:0]  OPB_O;
  logic [3:0]  RES0_I;
  logic [3:0]  RES1_I;
  logic [3:0]  RES2_I;

  int checks = 0;
  int failures = 0;

  w_cpu_io_nibble_bridge dut (
    .UserCLK(UserCLK), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_bytes(rx_bytes), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_ovf(err_ovf), .err_abort(err_abort), .err_clr(err_clr),
    .OPA_O(OPA_O), .OPB_O(OPB_O),
    .RES0_I(RES0_I), .RES1_I(RES1_I), .RES2_I(RES2_I)
  );

  always #5 UserCLK = ~UserCLK;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] word;
    int          stall_at;
    int          stall_len;
  } tx_vec_t;

  typedef struct {
    logic [31:0] bytes;
    int          n;
    bit          last;
    logic [31:0] exp_data;
    logic [2:0]  exp_bytes;
  } rx_vec_t;

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tx_run(input logic [31:0] w, input int sa, input int sl);
    logic [3:0] nib;
    logic [3:0] eb;
    tx_data  = w;
    tx_valid = 1'b1;
    RES2_I   = 4'b0100;
    step();
    tx_valid = 1'b0;
    tx_data  = ~w;
    chk("tx_ready_busy", 32'(tx_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      nib = w[4*k +: 4];
      eb  = {^nib, k == 7, k == 0, 1'b1};
      if (k == sa) begin
        RES2_I = 4'b0000;
        for (int s = 0; s < sl; s++) begin
          step();
          chk("tx_hold_opa", 32'(OPA_O), 32'(nib));
          chk("tx_hold_opb", 32'(OPB_O), 32'(eb));
        end
        RES2_I = 4'b0100;
      end
      chk("tx_opa", 32'(OPA_O), 32'(nib));
      chk("tx_opb", 32'(OPB_O), 32'(eb));
      step();
    end
    chk("tx_done_opa", 32'(OPA_O), 32'd0);
    chk("tx_done_opb", 32'(OPB_O), 32'd0);
    chk("tx_done_ready", 32'(tx_ready), 32'd1);
    RES2_I = 4'b0000;
  endtask

  task automatic rx_run(input logic [31:0] b, input int n, input bit last,
                        input logic [31:0] ed, input logic [2:0] en);
    for (int i = 0; i < n; i++) begin
      {RES1_I, RES0_I} = b[8*i +: 8];
      RES2_I = {2'b00, last && (i == n - 1), 1'b1};
      step();
    end
    RES2_I = 4'b0000;
    {RES1_I, RES0_I} = 8'h00;
    chk("rx_valid", 32'(rx_valid), 32'd1);
    chk("rx_data", rx_data, ed);
    chk("rx_bytes", 32'(rx_bytes), 32'(en));
  endtask

  tx_vec_t txv[3];
  rx_vec_t rxv[5];

  initial begin
    txv[0] = '{32'h87654321, -1, 0};
    txv[1] = '{32'h87654321, 4, 3};
    txv[2] = '{32'hF00FA5C3, 0, 2};
    rxv[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 3'd4};
    rxv[1] = '{32'h0000CDAB, 2, 1'b1, 32'h0000CDAB, 3'd2};
    rxv[2] = '{32'h0000005A, 1, 1'b1, 32'h0000005A, 3'd1};
    rxv[3] = '{32'h00030201, 3, 1'b1, 32'h00030201, 3'd3};
    rxv[4] = '{32'hCCDDEEFF, 4, 1'b1, 32'hCCDDEEFF, 3'd4};

    rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    RES0_I = '0; RES1_I = '0; RES2_I = '0;
    #12;
    chk("rst_opa", 32'(OPA_O), 32'd0);
    chk("rst_opb", 32'(OPB_O), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_rx_bytes", 32'(rx_bytes), 32'd0);
    chk("rst_err_ovf", 32'(err_ovf), 32'd0);
    chk("rst_err_abort", 32'(err_abort), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    foreach (txv[i]) tx_run(txv[i].word, txv[i].stall_at, txv[i].stall_len);

    rx_ready = 1'b1;
    foreach (rxv[i]) begin
      rx_run(rxv[i].bytes, rxv[i].n, rxv[i].last, rxv[i].exp_data, rxv[i].exp_bytes);
      step();
      chk("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
    end
    chk("no_err_ovf", 32'(err_ovf), 32'd0);

    rx_ready = 1'b0;
    rx_run(32'h44332211, 4, 1'b0, 32'h44332211, 3'd4);
    rx_run(32'h88776655, 4, 1'b0, 32'h44332211, 3'd4);
    chk("ovf_set", 32'(err_ovf), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", 32'(err_ovf), 32'd0);
    chk("ovf_hold_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    rx_run(32'h00000077, 1, 1'b1, 32'h00000077, 3'd1);
    chk("replace_no_ovf", 32'(err_ovf), 32'd0);
    step();
    chk("replace_consumed", 32'(rx_valid), 32'd0);

    tx_data = 32'h87654321; tx_valid = 1'b1; RES2_I = 4'b0100;
    step();
    tx_valid = 1'b0;
    step();
    {RES1_I, RES0_I} = 8'h11; RES2_I = 4'b0101;
    step();
    {RES1_I, RES0_I} = 8'h22; RES2_I = 4'b0101;
    step();
    chk("abort_pre_opa", 32'(OPA_O), 32'd4);
    {RES1_I, RES0_I} = 8'h33; RES2_I = 4'b1101;
    step();
    RES2_I = 4'b0000; {RES1_I, RES0_I} = 8'h00;
    chk("abort_opa", 32'(OPA_O), 32'd0);
    chk("abort_opb", 32'(OPB_O), 32'd0);
    chk("abort_tx_ready", 32'(tx_ready), 32'd1);
    chk("abort_err", 32'(err_abort), 32'd1);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    step();
    chk("abort_sticky", 32'(err_abort), 32'd1);
    chk("abort_tx_idle", 32'(OPB_O), 32'd0);
    rx_run(32'hA4A3A2A1, 4, 1'b0, 32'hA4A3A2A1, 3'd4);
    step();
    err_clr = 1'b1; RES2_I = 4'b1000;
    step();
    RES2_I = 4'b0000;
    chk("abort_set_wins", 32'(err_abort), 32'd1);
    step();
    err_clr = 1'b0;
    chk("abort_clr", 32'(err_abort), 32'd0);

    tx_data = 32'h87654321; tx_valid = 1'b1; RES2_I = 4'b0100;
    step();
    tx_valid = 1'b0;
    step();
    step();
    chk("midrst_pre_opa", 32'(OPA_O), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_opa", 32'(OPA_O), 32'd0);
    chk("midrst_opb", 32'(OPB_O), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    RES2_I = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    tx_run(32'h13579BDF, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
